// File: rtl/bus_timing_ctrl.sv
// CPU bus timing control: A-bus speed decode, MEMSEL decode, refresh/DMA stop generation.
// Refresh stalls are built only when BUS_TIMING_REFRESH_EN is defined.
package bus_pkg;
  typedef enum logic [1:0] {
    MEM_SLOW  = 2'd0,
    MEM_FAST  = 2'd1,
    MEM_XSLOW = 2'd2,
    MEM_VAR   = 2'd3
  } mem_speed_type;
endpackage

module bus_timing_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_access,
  input  logic                  cpu_wr,
  input  logic [23:0]           cpu_addr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_en,
  input  logic                  refresh_req,
  input  logic                  dma_req,
  output logic                  mem_access,
  output bus_pkg::mem_speed_type mem_speed,
  output logic                  speed_change,
  output logic                  new_speed,
  output logic                  stop,
  output logic                  dma_ack,
  output logic                  refresh_busy
);
  import bus_pkg::*;

  localparam logic [5:0] REF_LOAD = 6'(REFRESH_CYCLES - 1);

  logic [7:0]  bank;
  logic [15:0] offset;
  logic        sys_bank;
  logic        boundary;
  logic        dma_ack_n;
  logic        busy_n;
  logic [6:0]  wdata_unused;

  assign bank     = cpu_addr[23:16];
  assign offset   = cpu_addr[15:0];
  assign sys_bank = ~bank[6];
  assign wdata_unused = cpu_wdata[7:1];

  always_comb begin
    mem_speed = MEM_SLOW;
    if (bank[7:6] == 2'b01) begin
      mem_speed = MEM_SLOW;
    end else if (bank[7:6] == 2'b11) begin
      mem_speed = MEM_VAR;
    end else if (offset < 16'h2000) begin
      mem_speed = MEM_SLOW;
    end else if (offset < 16'h4000) begin
      mem_speed = MEM_FAST;
    end else if (offset < 16'h4200) begin
      mem_speed = MEM_XSLOW;
    end else if (offset < 16'h6000) begin
      mem_speed = MEM_FAST;
    end else if (offset < 16'h8000) begin
      mem_speed = MEM_SLOW;
    end else begin
      mem_speed = bank[7] ? MEM_VAR : MEM_SLOW;
    end
  end

  assign mem_access   = cpu_access;
  assign speed_change = cpu_access & cpu_wr & sys_bank & (offset == 16'h420D);
  assign new_speed    = cpu_wdata[0];

  // While stopped the speed counter sits at 0, so every clk counts as a boundary.
  assign boundary  = cpu_en | stop;
  assign dma_ack_n = dma_req & (dma_ack | boundary);

`ifdef BUS_TIMING_REFRESH_EN
  logic       ref_pend;
  logic       ref_pend_n;
  logic [5:0] ref_cnt;
  logic [5:0] ref_cnt_n;

  // Requests landing while pending, busy, or on the start clk are dropped.
  always_comb begin
    ref_pend_n = ref_pend;
    ref_cnt_n  = ref_cnt;
    busy_n     = refresh_busy;
    if (refresh_busy) begin
      if (ref_cnt == '0) begin
        busy_n = 1'b0;
      end else begin
        ref_cnt_n = ref_cnt - 6'd1;
      end
    end else if (ref_pend && boundary) begin
      ref_pend_n = 1'b0;
      ref_cnt_n  = REF_LOAD;
      busy_n     = 1'b1;
    end else if (refresh_req) begin
      ref_pend_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_pend     <= 1'b0;
      ref_cnt      <= '0;
      refresh_busy <= 1'b0;
    end else begin
      ref_pend     <= ref_pend_n;
      ref_cnt      <= ref_cnt_n;
      refresh_busy <= busy_n;
    end
  end
`else
  logic [6:0] refresh_unused;

  assign refresh_unused = {refresh_req, REF_LOAD};
  assign busy_n         = 1'b0;
  assign refresh_busy   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      dma_ack <= 1'b0;
      stop    <= 1'b0;
    end else begin
      dma_ack <= dma_ack_n;
      stop    <= busy_n | dma_ack_n;
    end
  end

endmodule

// File: tb/tb_bus_timing_ctrl.sv
// Directed self-checking bench for bus_timing_ctrl; refresh scenarios follow BUS_TIMING_REFRESH_EN.
module tb_bus_timing_ctrl;
  import bus_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_access;
  logic          cpu_wr;
  logic [23:0]   cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_en;
  logic          refresh_req;
  logic          dma_req;
  logic          mem_access;
  mem_speed_type mem_speed;
  logic          speed_change;
  logic          new_speed;
  logic          stop;
  logic          dma_ack;
  logic          refresh_busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bus_timing_ctrl #(.REFRESH_CYCLES(40)) dut (
    .clk(clk), .reset(reset), .cpu_access(cpu_access), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_en(cpu_en),
    .refresh_req(refresh_req), .dma_req(dma_req), .mem_access(mem_access),
    .mem_speed(mem_speed), .speed_change(speed_change), .new_speed(new_speed),
    .stop(stop), .dma_ack(dma_ack), .refresh_busy(refresh_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [23:0]   dec_addr [8];
  mem_speed_type dec_exp  [8];

  initial begin
    int unsigned n;

    dec_addr[0] = 24'h002100; dec_exp[0] = MEM_FAST;
    dec_addr[1] = 24'h004016; dec_exp[1] = MEM_XSLOW;
    dec_addr[2] = 24'h7E0000; dec_exp[2] = MEM_SLOW;
    dec_addr[3] = 24'h808000; dec_exp[3] = MEM_VAR;
    dec_addr[4] = 24'h008000; dec_exp[4] = MEM_SLOW;
    dec_addr[5] = 24'hC00000; dec_exp[5] = MEM_VAR;
    dec_addr[6] = 24'h001FFF; dec_exp[6] = MEM_SLOW;
    dec_addr[7] = 24'h004200; dec_exp[7] = MEM_FAST;

    reset = 1'b1; cpu_access = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_en = 1'b0; refresh_req = 1'b0; dma_req = 1'b0;
    tick(); tick();
    chk("reset_stop", 32'(stop), 32'd0);
    chk("reset_dma_ack", 32'(dma_ack), 32'd0);
    chk("reset_refresh_busy", 32'(refresh_busy), 32'd0);
    reset = 1'b0;
    tick();

    // Address decode sweep
    cpu_access = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_addr = dec_addr[i];
      #1;
      chk($sformatf("decode_%06h", dec_addr[i]), 32'(mem_speed), 32'(dec_exp[i]));
    end
    chk("mem_access_hi", 32'(mem_access), 32'd1);

    // MEMSEL write decode
    cpu_wr = 1'b1; cpu_wdata = 8'h01; cpu_addr = 24'h00420D;
    #1;
    chk("memsel_change", 32'(speed_change), 32'd1);
    chk("memsel_new_speed", 32'(new_speed), 32'd1);
    cpu_addr = 24'h40420D;
    #1;
    chk("memsel_bank40", 32'(speed_change), 32'd0);
    cpu_addr = 24'h00420D; cpu_wr = 1'b0;
    #1;
    chk("memsel_read", 32'(speed_change), 32'd0);
    cpu_access = 1'b0;
    #1;
    chk("mem_access_lo", 32'(mem_access), 32'd0);
    chk("memsel_no_access", 32'(speed_change), 32'd0);
    tick();

    // DMA halt aligned to the next cpu_en
    dma_req = 1'b1;
    tick();
    chk("dma_wait_ack", 32'(dma_ack), 32'd0);
    chk("dma_wait_stop", 32'(stop), 32'd0);
    cpu_en = 1'b1;
    #1;
    chk("dma_no_comb_stop", 32'(stop), 32'd0);
    tick();
    cpu_en = 1'b0;
    chk("dma_ack_rise", 32'(dma_ack), 32'd1);
    chk("dma_stop_rise", 32'(stop), 32'd1);
    tick();
    chk("dma_ack_hold", 32'(dma_ack), 32'd1);
    dma_req = 1'b0;
    tick();
    chk("dma_ack_fall", 32'(dma_ack), 32'd0);
    chk("dma_stop_fall", 32'(stop), 32'd0);
    tick();

`ifdef BUS_TIMING_REFRESH_EN
    // Refresh stall: 40 clks, second request during the stall dropped
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    tick();
    chk("ref_pend_no_stop", 32'(stop), 32'd0);
    cpu_en = 1'b1; tick(); cpu_en = 1'b0;
    chk("ref_start_busy", 32'(refresh_busy), 32'd1);
    n = 0;
    while (stop && n < 100) begin
      n++;
      refresh_req = (n == 5);
      tick();
    end
    refresh_req = 1'b0;
    chk("ref_len", n, 32'd40);
    chk("ref_end_busy", 32'(refresh_busy), 32'd0);
    cpu_en = 1'b1; tick(); cpu_en = 1'b0;
    chk("ref_dropped_req", 32'(stop), 32'd0);
    tick();

    // Refresh overlapped by DMA
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    cpu_en = 1'b1; tick(); cpu_en = 1'b0;
    chk("ovl_start", 32'(stop), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    dma_req = 1'b1;
    tick();
    chk("ovl_dma_ack", 32'(dma_ack), 32'd1);
    n = 0;
    for (int i = 0; i < 49; i++) begin
      if (stop) n++;
      tick();
    end
    chk("ovl_stop_held", n, 32'd49);
    chk("ovl_refresh_done", 32'(refresh_busy), 32'd0);
    chk("ovl_stop_still", 32'(stop), 32'd1);
    dma_req = 1'b0;
    tick();
    chk("ovl_stop_fall", 32'(stop), 32'd0);
    chk("ovl_ack_fall", 32'(dma_ack), 32'd0);
    tick();

    // Reset at ref_cnt == 20, then a full-length stall
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    cpu_en = 1'b1; tick(); cpu_en = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("rst_mid_busy", 32'(refresh_busy), 32'd1);
    reset = 1'b1; dma_req = 1'b1;
    tick();
    reset = 1'b0; dma_req = 1'b0;
    chk("rst_mid_stop", 32'(stop), 32'd0);
    chk("rst_mid_ack", 32'(dma_ack), 32'd0);
    chk("rst_mid_busy_clr", 32'(refresh_busy), 32'd0);
    cpu_en = 1'b1; tick(); cpu_en = 1'b0;
    chk("rst_pend_clr", 32'(stop), 32'd0);
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    cpu_en = 1'b1; tick(); cpu_en = 1'b0;
    n = 0;
    while (stop && n < 100) begin
      n++;
      tick();
    end
    chk("rst_full_len", n, 32'd40);
`else
    // Refresh compiled out: requests have no effect
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    cpu_en = 1'b1; tick(); cpu_en = 1'b0;
    chk("noref_stop", 32'(stop), 32'd0);
    chk("noref_busy", 32'(refresh_busy), 32'd0);
    tick();
    chk("noref_stop_later", 32'(stop), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_timing_ctrl.md
Name: bus_timing_ctrl

Overview:
- Upstream control stage for the memory access speed counter. Decodes the CPU A-bus address into a speed class and decodes MEMSEL ($420D) writes into speed-change requests.
- Generates the registered `stop` that freezes the CPU clock counter for DRAM refresh and DMA halts. All stalls are aligned to CPU cycle boundaries.
- Sits between the CPU bus request logic, the PPU H-timing and DMA controllers, and the speed counter.

Parameters:
- REFRESH_CYCLES, 40, master clocks `stop` is held per refresh stall. Legal range 1-63.

Ports:
- clk  in  1  master clock
- reset  in  1  reset
- cpu_access  in  1  CPU drives a valid bus cycle this CPU cycle
- cpu_wr  in  1  bus cycle is a write
- cpu_addr  in  24  A-bus address {bank, offset}
- cpu_wdata  in  8  write data
- cpu_en  in  1  CPU cycle boundary strobe, fed back from the speed counter
- refresh_req  in  1  one-clk pulse from H-timing at the refresh position
- dma_req  in  1  level; DMA/HDMA engine requests CPU halt
- mem_access  out  1  to speed counter
- mem_speed  out  mem_speed_type  speed class (bus_pkg)
- speed_change  out  1  MEMSEL write decoded
- new_speed  out  1  MEMSEL bit 0
- stop  out  1  CPU counter freeze, registered
- dma_ack  out  1  CPU halted for DMA, registered
- refresh_busy  out  1  refresh stall in progress, registered

Behaviour:
- Reset is synchronous and active-high (`reset`); the clock is `clk`. All registered outputs reset to 0; the refresh-pending flag and the counter reset to 0.
- Combinational decode, bank b = cpu_addr[23:16], offset o = cpu_addr[15:0]:
  - b in $40-$7F: MEM_SLOW.
  - b in $C0-$FF: MEM_VAR.
  - b in $00-$3F or $80-$BF:
    - o $0000-$1FFF: SLOW
    - o $2000-$3FFF: FAST
    - o $4000-$41FF: XSLOW
    - o $4200-$5FFF: FAST
    - o $6000-$7FFF: SLOW
    - o $8000-$FFFF: SLOW if b[7]=0, VAR if b[7]=1
- mem_access = cpu_access. mem_speed is driven from the decode regardless of cpu_access.
- speed_change = cpu_access & cpu_wr & (b in $00-$3F or $80-$BF) & (o == $420D). It is not gated by cpu_en; the speed counter commits on its own cpu_en.
- new_speed = cpu_wdata[0].
- boundary = cpu_en | stop. While stop=1 the counter is frozen at 0, so a new stall may join immediately.
- Refresh:
  - A refresh_req pulse sets ref_pend.
  - On a clk where ref_pend & boundary: clear ref_pend, load ref_cnt = REFRESH_CYCLES-1, set refresh_busy.
  - While refresh_busy: decrement ref_cnt each clk. When ref_cnt==0, clear refresh_busy on that edge.
  - Result: refresh_busy is high for exactly REFRESH_CYCLES clks.
  - refresh_req arriving while ref_pend or refresh_busy is dropped.
  - refresh_req arriving on the same clk that the stall starts is also dropped.
- DMA:
  - dma_ack_next = dma_req & (dma_ack | boundary).
  - dma_ack rises on the clk after a boundary with dma_req high.
  - dma_ack falls on the clk after dma_req drops.
- stop = refresh_busy | dma_ack, formed from next-state terms so that all three are registered together.
  - Refresh and DMA overlapping: stop stays high until both end.
  - The refresh count continues during DMA.
- Latency: a request present on a clk with cpu_en=1 gives stop=1 on the next clk. There is no combinational path from cpu_en to stop.
- Reset mid-stall: stop, dma_ack, refresh_busy and ref_pend are all 0 on the next clk.

Optional Feature:
- Macro: BUS_TIMING_REFRESH_EN.
- Defined: refresh logic as above.
- Undefined: refresh_req is ignored, refresh_busy is tied to 0, and stop = dma_ack only. Decode and DMA behaviour are unchanged.

Test Plan:
- Decode sweep:
  - $00:2100 -> FAST
  - $00:4016 -> XSLOW
  - $7E:0000 -> SLOW
  - $80:8000 -> VAR
  - $00:8000 -> SLOW
  - $C0:0000 -> VAR
  - $00:1FFF -> SLOW
  - $00:4200 -> FAST
- Write $01 to $00:420D with cpu_access=1, cpu_wr=1 -> speed_change=1, new_speed=1. Same address from bank $40 -> speed_change=0.
- refresh_req pulse, cpu_en high 3 clks later -> stop=1 starting the clk after that cpu_en, for exactly 40 clks, then 0. A second refresh_req during the stall is ignored.
- dma_req raised mid-cycle -> dma_ack and stop rise the clk after the next cpu_en. Drop dma_req -> both fall on the next clk.
- Refresh starts, then dma_req rises 10 clks in -> dma_ack rises the next clk. dma_req held 50 clks -> stop remains high until dma_ack falls, even though refresh_busy fell earlier.
- Assert reset during a refresh stall at ref_cnt=20 -> all outputs 0 on the next clk. A subsequent refresh lasts the full 40 clks.
